// File: rtl/wb_retire_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_retire_stage_pkg
// Shared latch layouts, opcodes and FSM encodings for the writeback stage.
// Rev    : 1.0
// ============================================================================
package wb_retire_stage_pkg;

    localparam int DBITS       = 32;
    localparam int REG_BITS    = 5;
    localparam int CSRNO_BITS  = 12;
    localparam int TYPE_BITS   = 4;
    localparam int CANARY_BITS = 16;
    localparam int WB_ERR_BITS = 2;

    localparam logic [CANARY_BITS-1:0] BUS_CANARY_VALUE   = 16'hCA5E;
    localparam logic [CSRNO_BITS-1:0]  HALT_CSRNO_DEFAULT = 12'h00F;

    localparam logic [1:0] WB_FSM_RUN       = 2'd0;
    localparam logic [1:0] WB_FSM_HALT_PEND = 2'd1;
    localparam logic [1:0] WB_FSM_HALT      = 2'd2;

    typedef enum logic [7:0] {
        INVALID_I = 8'd0,
        ADDI_I    = 8'd1,
        ADD_I     = 8'd2,
        CSRW_I    = 8'd3
    } op_t;

    typedef struct packed {
        logic [DBITS-1:0]       inst;
        logic [DBITS-1:0]       pc;
        op_t                    op_I;
        logic [DBITS-1:0]       inst_count;
        logic                   wr_reg;
        logic [REG_BITS-1:0]    rd;
        logic [DBITS-1:0]       result;
        logic                   wr_csr;
        logic [CSRNO_BITS-1:0]  wcsrno;
        logic [TYPE_BITS-1:0]   type_I;
        logic [CANARY_BITS-1:0] bus_canary;
    } mem_latch_t;

    // Field order here is the contract with the decode stage.
    typedef struct packed {
        logic                  wr_reg;
        logic [REG_BITS-1:0]   wregno;
        logic [DBITS-1:0]      regval;
        logic [CSRNO_BITS-1:0] wcsrno;
        logic                  wr_csr;
        logic [REG_BITS-1:0]   rd;
        logic [TYPE_BITS-1:0]  type_I;
    } wb_to_de_t;

    localparam int MEM_LATCH_WIDTH = $bits(mem_latch_t);
    localparam int WB_LATCH_WIDTH  = $bits(mem_latch_t);
    localparam int WB_TO_DE_WIDTH  = $bits(wb_to_de_t);

endpackage
`default_nettype wire

// File: rtl/wb_retire_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : wb_retire_stage_sat_counter
// Saturating up-counter with asynchronous active-low clear.
// Rev    : 1.0
// ============================================================================
module wb_retire_stage_sat_counter #(
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    output logic [CNT_BITS-1:0] cnt_o
);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_BITS{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module : wb_retire_stage
// Writeback/retire: register/CSR write port to DE, instret, halt FSM, errors.
// Rev    : 1.0
// ============================================================================
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int                    CNT_BITS   = 32,
    parameter logic [CSRNO_BITS-1:0] HALT_CSRNO = HALT_CSRNO_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [MEM_LATCH_WIDTH-1:0] from_MEM_latch,
    output logic [WB_TO_DE_WIDTH-1:0]  from_WB_to_DE,
    output logic [CNT_BITS-1:0]        instret,
    output logic [DBITS-1:0]           retire_pc,
    output logic                       halted,
    output logic [WB_ERR_BITS-1:0]     err_flags
);

    mem_latch_t             latch_q;
    logic [1:0]             fsm_q;
    logic [1:0]             fsm_d;
    logic [DBITS-1:0]       retire_pc_q;
    logic [DBITS-1:0]       retire_pc_d;
    logic [WB_ERR_BITS-1:0] err_q;
    logic [WB_ERR_BITS-1:0] err_d;

    logic      w_valid;
    logic      w_retire;
    logic      w_halt_req;
    wb_to_de_t w_de;
    logic      w_unused_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= '0;
        end else begin
            latch_q <= from_MEM_latch;
        end
    end

    // Only RUN retires: HALT_PEND holds wrong-path work after the halt CSRW.
    assign w_valid    = (latch_q.op_I != INVALID_I);
    assign w_retire   = w_valid && (fsm_q == WB_FSM_RUN);
    assign w_halt_req = w_retire && (latch_q.op_I == CSRW_I) && (latch_q.wcsrno == HALT_CSRNO);

    always_comb begin
        w_de        = '0;
        w_de.wr_reg = w_retire && latch_q.wr_reg && (latch_q.rd != '0);
        w_de.wr_csr = w_retire && latch_q.wr_csr && !latch_q.wr_reg;
        w_de.wregno = latch_q.rd;
        w_de.regval = latch_q.result;
        w_de.wcsrno = latch_q.wcsrno;
        if (w_retire) begin
            w_de.rd     = latch_q.rd;
            w_de.type_I = latch_q.type_I;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            WB_FSM_RUN:       if (w_halt_req) fsm_d = WB_FSM_HALT_PEND;
            WB_FSM_HALT_PEND: fsm_d = WB_FSM_HALT;
            WB_FSM_HALT:      fsm_d = WB_FSM_HALT;
            default:          fsm_d = WB_FSM_HALT;
        endcase
    end

    always_comb begin
        retire_pc_d = retire_pc_q;
        err_d       = err_q;
        if (w_retire) begin
            retire_pc_d = latch_q.pc;
            if (latch_q.bus_canary != BUS_CANARY_VALUE) err_d[1] = 1'b1;
            if (latch_q.wr_reg && latch_q.wr_csr)       err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= WB_FSM_RUN;
            retire_pc_q <= '0;
            err_q       <= '0;
        end else begin
            fsm_q       <= fsm_d;
            retire_pc_q <= retire_pc_d;
            err_q       <= err_d;
        end
    end

    wb_retire_stage_sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_instret (
        .clk   (clk),
        .rst_n (reset_n),
        .inc_i (w_retire),
        .cnt_o (instret)
    );

    assign w_unused_ok   = &{1'b0, latch_q.inst, latch_q.inst_count};
    assign from_WB_to_DE = w_de;
    assign retire_pc     = retire_pc_q;
    assign halted        = (fsm_q == WB_FSM_HALT);
    assign err_flags     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_retire_stage
// Directed self-checking bench for wb_retire_stage (plus a narrow-counter copy).
// Rev    : 1.0
// ============================================================================
module tb_wb_retire_stage;
    import wb_retire_stage_pkg::*;

    logic                       clk;
    logic                       reset_n;
    logic [MEM_LATCH_WIDTH-1:0] from_MEM_latch;
    logic [WB_TO_DE_WIDTH-1:0]  from_WB_to_DE;
    logic [31:0]                instret;
    logic [DBITS-1:0]           retire_pc;
    logic                       halted;
    logic [1:0]                 err_flags;

    logic [WB_TO_DE_WIDTH-1:0]  s_de;
    logic [2:0]                 s_instret;
    logic [DBITS-1:0]           s_retire_pc;
    logic                       s_halted;
    logic [1:0]                 s_err_flags;

    wb_to_de_t de;
    assign de = from_WB_to_DE;

    int checks   = 0;
    int failures = 0;

    wb_retire_stage #(.CNT_BITS(32)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .from_MEM_latch (from_MEM_latch),
        .from_WB_to_DE  (from_WB_to_DE),
        .instret        (instret),
        .retire_pc      (retire_pc),
        .halted         (halted),
        .err_flags      (err_flags)
    );

    // Narrow counter copy exercises saturation in a handful of retires.
    wb_retire_stage #(.CNT_BITS(3)) u_dut_sat (
        .clk            (clk),
        .reset_n        (reset_n),
        .from_MEM_latch (from_MEM_latch),
        .from_WB_to_DE  (s_de),
        .instret        (s_instret),
        .retire_pc      (s_retire_pc),
        .halted         (s_halted),
        .err_flags      (s_err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_latch_t mk(input op_t op, input logic [31:0] pc,
                                      input logic wr_reg, input logic [4:0] rd,
                                      input logic [31:0] result, input logic wr_csr,
                                      input logic [11:0] wcsrno, input logic [15:0] canary);
        mem_latch_t m;
        m            = '0;
        m.inst       = 32'h0000_0013;
        m.pc         = pc;
        m.op_I       = op;
        m.wr_reg     = wr_reg;
        m.rd         = rd;
        m.result     = result;
        m.wr_csr     = wr_csr;
        m.wcsrno     = wcsrno;
        m.type_I     = 4'h3;
        m.bus_canary = canary;
        return m;
    endfunction

    // Present a latch value before a posedge; return 1 time unit after it.
    task automatic step(input mem_latch_t m);
        @(negedge clk);
        from_MEM_latch = m;
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] GOOD = BUS_CANARY_VALUE;

    initial begin
        reset_n        = 1'b0;
        from_MEM_latch = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_reg",  de.wr_reg, 0);
        chk("rst_de_all",  from_WB_to_DE, 0);
        chk("rst_instret", instret, 0);
        chk("rst_pc",      retire_pc, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_err",     err_flags, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ADDI x5 = 0x2A
        step(mk(ADDI_I, 32'h100, 1'b1, 5'd5, 32'h2A, 1'b0, 12'h0, GOOD));
        chk("addi_wr_reg", de.wr_reg, 1);
        chk("addi_wregno", de.wregno, 5);
        chk("addi_regval", de.regval, 32'h2A);
        chk("addi_rd",     de.rd, 5);
        chk("addi_cnt_pre", instret, 0);
        step('0);
        chk("addi_one_cycle", de.wr_reg, 0);
        chk("addi_instret", instret, 1);
        chk("addi_pc",      retire_pc, 32'h100);

        // ADD x0 = 7: no write, rd 0, still counted
        step(mk(ADD_I, 32'h104, 1'b1, 5'd0, 32'h7, 1'b0, 12'h0, GOOD));
        chk("x0_wr_reg", de.wr_reg, 0);
        chk("x0_rd",     de.rd, 0);
        step('0);
        chk("x0_instret", instret, 2);

        // Valid, 3 bubbles, valid
        step(mk(ADDI_I, 32'h108, 1'b1, 5'd3, 32'h11, 1'b0, 12'h0, GOOD));
        chk("b_first_wr", de.wr_reg, 1);
        for (int i = 0; i < 3; i++) begin
            step('0);
            chk("b_bubble_wr",  de.wr_reg, 0);
            chk("b_bubble_csr", de.wr_csr, 0);
            chk("b_bubble_rd",  de.rd, 0);
        end
        chk("b_mid_instret", instret, 3);
        step(mk(ADDI_I, 32'h10C, 1'b1, 5'd4, 32'h22, 1'b0, 12'h0, GOOD));
        step('0);
        chk("b_instret", instret, 4);
        chk("b_pc",      retire_pc, 32'h10C);

        // Reg+CSR conflict with bad canary
        step(mk(ADDI_I, 32'h110, 1'b1, 5'd6, 32'h33, 1'b1, 12'h7, 16'hDEAD));
        chk("cf_wr_reg", de.wr_reg, 1);
        chk("cf_wr_csr", de.wr_csr, 0);
        chk("cf_wregno", de.wregno, 6);
        step('0);
        chk("cf_err",     err_flags, 2'b11);
        chk("cf_instret", instret, 5);

        // Four more retires: narrow counter sits at 7 after reaching it
        for (int i = 0; i < 4; i++) begin
            step(mk(ADDI_I, 32'h120 + 32'(4 * i), 1'b1, 5'd7, 32'(i), 1'b0, 12'h0, GOOD));
        end
        step('0);
        chk("sat_main_instret", instret, 9);
        chk("sat_narrow",       s_instret, 3'b111);
        chk("sat_err_sticky",   err_flags, 2'b11);
        chk("sat_pc",           retire_pc, 32'h12C);

        // Asynchronous reset in the middle of a write
        step(mk(ADDI_I, 32'h140, 1'b1, 5'd9, 32'h99, 1'b0, 12'h0, GOOD));
        chk("ar_pre_wr", de.wr_reg, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_wr_reg",  de.wr_reg, 0);
        chk("ar_instret", instret, 0);
        chk("ar_narrow",  s_instret, 0);
        chk("ar_err",     err_flags, 0);
        chk("ar_pc",      retire_pc, 0);
        chk("ar_halted",  halted, 0);
        @(negedge clk);
        from_MEM_latch = '0;
        reset_n        = 1'b1;

        // Halt CSRW followed by wrong-path ADDIs
        step(mk(CSRW_I, 32'h200, 1'b0, 5'd0, 32'h55, 1'b1, 12'h00F, GOOD));
        chk("h_wr_csr", de.wr_csr, 1);
        chk("h_wcsrno", de.wcsrno, 12'h00F);
        chk("h_regval", de.regval, 32'h55);
        chk("h_halted0", halted, 0);
        step(mk(ADDI_I, 32'h204, 1'b1, 5'd1, 32'h1, 1'b0, 12'h0, GOOD));
        chk("hp_wr_reg",  de.wr_reg, 0);
        chk("hp_rd",      de.rd, 0);
        chk("hp_halted",  halted, 0);
        chk("hp_instret", instret, 1);
        step(mk(ADDI_I, 32'h208, 1'b1, 5'd2, 32'h2, 1'b0, 12'h0, GOOD));
        chk("hl_halted",  halted, 1);
        chk("hl_wr_reg",  de.wr_reg, 0);
        chk("hl_instret", instret, 1);
        chk("hl_pc",      retire_pc, 32'h200);
        step(mk(CSRW_I, 32'h20C, 1'b0, 5'd0, 32'h66, 1'b1, 12'h00F, GOOD));
        chk("hl_csr_ignored", de.wr_csr, 0);
        step('0);
        chk("hl_still_halted", halted, 1);
        chk("hl_final_cnt",    instret, 1);
        chk("hl_final_pc",     retire_pc, 32'h200);
        chk("hl_err_clean",    err_flags, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
